// File: rtl/mux_sweep_pkg.sv
// mux_sweep_pkg: shared types, sizes and golden-vector function for the mux sweep sequencer.
// Rev 1.0
`default_nettype none

package mux_sweep_pkg;

  localparam int NUM_VECTORS = 8;
  localparam int PROBE_W     = 9;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // Vector index is {S, I1, I0}; node order is I0, I1, S, S, S, ~S, I1&S, I0&~S, 1.
  function automatic logic [PROBE_W-1:0] expected_probe(input logic [2:0] v);
    logic s, i1, i0;
    s  = v[2];
    i1 = v[1];
    i0 = v[0];
    return {1'b1, i0 & ~s, i1 & s, ~s, s, s, s, i1, i0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_probe_checker.sv
// mux_probe_checker: compares the observed mux node vector against the golden vector for v.
// Rev 1.0
`default_nettype none

module mux_probe_checker
  import mux_sweep_pkg::*;
(
  input  logic [2:0]         vec,
  input  logic [PROBE_W-1:0] probe,
  output logic               mismatch,
  output logic [PROBE_W-1:0] diff
);

  always_comb begin
    diff     = probe ^ expected_probe(vec);
    mismatch = |diff;
  end

endmodule

`default_nettype wire

// File: rtl/mux_sweep_ctrl.sv
// mux_sweep_ctrl: walks the 2:1 mux through all 8 input vectors and records per-vector node failures.
// Rev 1.0
`default_nettype none

module mux_sweep_ctrl
  import mux_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               mux_s,
  output logic               mux_i0,
  output logic               mux_i1,
  input  logic [PROBE_W-1:0] probe,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [3:0]         err_count,
  output logic [7:0]         fail_map
);

  localparam logic [3:0] C_SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t             r_state;
  logic [2:0]         r_vec;
  logic [3:0]         r_cnt;
  logic               w_mismatch;
  logic [PROBE_W-1:0] w_diff;
  logic               w_fail;

  mux_probe_checker u_checker (
    .vec      (r_vec),
    .probe    (probe),
    .mismatch (w_mismatch),
    .diff     (w_diff)
  );

  assign w_fail = w_mismatch | (|w_diff);

  // The vector register is the drive register: outputs follow v and hold it after the sweep.
  assign mux_s  = r_vec[2];
  assign mux_i1 = r_vec[1];
  assign mux_i0 = r_vec[0];
  assign done   = (r_state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_vec     <= 3'd0;
      r_cnt     <= 4'd0;
      busy      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 4'd0;
      fail_map  <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_SETTLE;
            r_vec     <= 3'd0;
            r_cnt     <= C_SETTLE_INIT;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= 4'd0;
            fail_map  <= 8'h00;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_SAMPLE: begin
          if (w_fail) begin
            err_count       <= err_count + 4'd1;
            fail_map[r_vec] <= 1'b1;
          end
          if (r_vec == 3'd7) begin
            // Final vector's result is folded in here so pass is valid during the done cycle.
            r_state <= ST_DONE;
            busy    <= 1'b0;
            pass    <= (err_count == 4'd0) && !w_fail;
          end else begin
            r_state <= ST_SETTLE;
            r_vec   <= r_vec + 3'd1;
            r_cnt   <= C_SETTLE_INIT;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_sweep_ctrl.sv
// tb_mux_sweep_ctrl: table-driven bench with two sequencers (settle 2 and settle 0) on a faultable mux model.
`default_nettype none

module tb_mux_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start, busy, done, pass, ms, mi0, mi1;
  logic [8:0] probe [2];
  logic [3:0] err_count [2];
  logic [7:0] fail_map [2];
  logic [8:0] stuck0, stuck1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [8:0] mux_nodes(input logic s, input logic i1, input logic i0);
    return {1'b1, i0 & ~s, i1 & s, ~s, s, s, s, i1, i0};
  endfunction

  assign probe[0] = (mux_nodes(ms[0], mi1[0], mi0[0]) & ~stuck0) | stuck1;
  assign probe[1] = (mux_nodes(ms[1], mi1[1], mi0[1]) & ~stuck0) | stuck1;

  mux_sweep_ctrl #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .mux_s(ms[0]), .mux_i0(mi0[0]), .mux_i1(mi1[0]), .probe(probe[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err_count[0]), .fail_map(fail_map[0])
  );

  mux_sweep_ctrl #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .mux_s(ms[1]), .mux_i0(mi0[1]), .mux_i1(mi1[1]), .probe(probe[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err_count[1]), .fail_map(fail_map[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_reset(input int sel, input string tag);
    chk({tag, "_busy"}, 32'(busy[sel]), 0);
    chk({tag, "_done"}, 32'(done[sel]), 0);
    chk({tag, "_pass"}, 32'(pass[sel]), 0);
    chk({tag, "_err"}, 32'(err_count[sel]), 0);
    chk({tag, "_map"}, 32'(fail_map[sel]), 0);
    chk({tag, "_drive"}, 32'({ms[sel], mi1[sel], mi0[sel]}), 0);
  endtask

  task automatic run_sweep(input int sel, input bit repulse, input int exp_len, input string tag);
    int len;
    bit got;
    bit pulsed;
    @(negedge clk);
    start[sel] = 1'b1;
    @(posedge clk);
    #1;
    start[sel] = 1'b0;
    chk({tag, "_busy_on"}, 32'(busy[sel]), 1);
    len    = 1;
    got    = 1'b0;
    pulsed = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (repulse && !pulsed && {ms[sel], mi1[sel], mi0[sel]} == 3'd3) begin
        start[sel] = 1'b1;
        pulsed     = 1'b1;
      end
      @(posedge clk);
      #1;
      start[sel] = 1'b0;
      if (done[sel]) got = 1'b1;
      else if (busy[sel]) len++;
    end
    chk({tag, "_done_seen"}, 32'(got), 1);
    chk({tag, "_len"}, 32'(len), 32'(exp_len));
    chk({tag, "_busy_in_done"}, 32'(busy[sel]), 0);
    @(posedge clk);
    #1;
    chk({tag, "_done_1cyc"}, 32'(done[sel]), 0);
  endtask

  typedef struct {
    int         sel;
    logic [8:0] s0;
    logic [8:0] s1;
    int         exp_err;
    logic [7:0] exp_map;
    logic       exp_pass;
    int         exp_len;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{0, 9'h000, 9'h000, 0, 8'h00, 1'b1, 32};
    tbl[1] = '{0, 9'h100, 9'h000, 8, 8'hFF, 1'b0, 32};
    tbl[2] = '{0, 9'h040, 9'h000, 2, 8'hC0, 1'b0, 32};
    tbl[3] = '{1, 9'h000, 9'h020, 4, 8'hF0, 1'b0, 16};
    tbl[4] = '{0, 9'h000, 9'h001, 4, 8'h55, 1'b0, 32};
    tbl[5] = '{1, 9'h000, 9'h080, 6, 8'hF5, 1'b0, 16};
    tbl[6] = '{1, 9'h000, 9'h000, 0, 8'h00, 1'b1, 16};
    tbl[7] = '{0, 9'h004, 9'h000, 4, 8'hF0, 1'b0, 32};

    rst_n  = 1'b0;
    start  = 2'b00;
    stuck0 = 9'h000;
    stuck1 = 9'h000;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_reset(0, "rst_a");
    chk_idle_reset(1, "rst_b");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      string tag;
      tag    = $sformatf("vec%0d", i);
      stuck0 = tbl[i].s0;
      stuck1 = tbl[i].s1;
      run_sweep(tbl[i].sel, 1'b0, tbl[i].exp_len, tag);
      chk({tag, "_err"}, 32'(err_count[tbl[i].sel]), 32'(tbl[i].exp_err));
      chk({tag, "_map"}, 32'(fail_map[tbl[i].sel]), 32'(tbl[i].exp_map));
      chk({tag, "_pass"}, 32'(pass[tbl[i].sel]), 32'(tbl[i].exp_pass));
      chk({tag, "_drive"}, 32'({ms[tbl[i].sel], mi1[tbl[i].sel], mi0[tbl[i].sel]}), 7);
    end

    // start re-pulsed while vector 3 is settling must be ignored
    stuck0 = 9'h000;
    stuck1 = 9'h000;
    run_sweep(0, 1'b1, 32, "repulse");
    chk("repulse_err", 32'(err_count[0]), 0);
    chk("repulse_map", 32'(fail_map[0]), 0);
    chk("repulse_pass", 32'(pass[0]), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("repulse_no_requeue", 32'(busy[0]), 0);

    // reset during vector 5 with a failing probe
    stuck0 = 9'h100;
    begin
      bit reached;
      reached = 1'b0;
      @(negedge clk);
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      for (int k = 0; k < 100 && !reached; k++) begin
        @(posedge clk);
        #1;
        if ({ms[0], mi1[0], mi0[0]} == 3'd5) reached = 1'b1;
      end
      chk("abort_reach_v5", 32'(reached), 1);
      chk("abort_pre_err", 32'(err_count[0]), 5);
      chk("abort_pre_map", 32'(fail_map[0]), 8'h1F);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle_reset(0, "abort");
      for (int k = 0; k < 3; k++) begin
        @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done[0]), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
    end

    stuck0 = 9'h000;
    run_sweep(0, 1'b0, 32, "post");
    chk("post_err", 32'(err_count[0]), 0);
    chk("post_map", 32'(fail_map[0]), 0);
    chk("post_pass", 32'(pass[0]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
